// File: rtl/line_mem_responder.sv
// Memory-side responder for the 128-bit cache line protocol: DEPTH-line store, fixed-latency mem_ready pulse.
// Optional `MEM_PROTOCOL_CHECK_EN adds a sticky proto_err output flagging requester handshake violations.
module line_mem_responder #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int IDX_W   = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              busy
`ifdef MEM_PROTOCOL_CHECK_EN
  ,
  output logic              proto_err
`endif
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic                op_write;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   wdata;
  logic                req;
  logic                commit;
  logic                commit_write;
  logic [IDX_W-1:0]    commit_idx;
  logic [DATA_W-1:0]   commit_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign req       = mem_read | mem_write;
  assign mem_ready = (state == READY);
  assign busy      = (state != IDLE);

  // WAIT commits on the edge where cnt decrements to 0, so READY lands exactly LATENCY cycles
  // after the request; with LATENCY=1 the commit uses the live inputs straight from IDLE.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    commit       = 1'b0;
    commit_write = op_write;
    commit_idx   = idx;
    commit_wdata = wdata;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt    = READY;
            commit       = 1'b1;
            commit_write = mem_write;
            commit_idx   = mem_addr[IDX_W-1:0];
            commit_wdata = mem_wdata;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) begin
          commit    = 1'b1;
          state_nxt = READY;
        end
      end
      READY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit && !commit_write) mem_rdata <= mem[commit_idx];
    end
  end

  // Request capture; write wins when both strobes are high.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op_write <= mem_write;
      idx      <= mem_addr[IDX_W-1:0];
      wdata    <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && commit && commit_write) mem[commit_idx] <= commit_wdata;
  end

`ifdef MEM_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] addr_q;
  logic              held;
  logic              viol_both, viol_chg, viol_drop;

  assign held      = op_write ? mem_write : mem_read;
  assign viol_both = mem_read & mem_write;
  assign viol_chg  = (state == WAIT) && held &&
                     ((mem_addr != addr_q) || (op_write && (mem_wdata != wdata)));
  assign viol_drop = (state == WAIT) && !held;

  always_ff @(posedge clk) begin
    if (state == IDLE && req) addr_q <= mem_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                 proto_err <= 1'b0;
    else if (viol_both || viol_chg || viol_drop) proto_err <= 1'b1;
  end

`ifndef SYNTHESIS
  int unsigned cyc;
  always_ff @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
    if (rst_n && viol_both) $display("proto: read and write both high at cycle %0d", cyc);
    if (rst_n && viol_chg)  $display("proto: address/data changed during wait at cycle %0d", cyc);
    if (rst_n && viol_drop) $display("proto: request dropped before ready at cycle %0d", cyc);
  end
`endif
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[ADDR_W-1:IDX_W];
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one instance at LATENCY=4, one at LATENCY=1 with a scoreboard.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rd0, wr0, rd1, wr1;
  logic [27:0]   ad0, ad1;
  logic [127:0]  wd0, wd1, q0, q1;
  logic          rdy0, rdy1, bz0, bz1;
`ifdef MEM_PROTOCOL_CHECK_EN
  logic          pe0, pe1;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  line_mem_responder #(.ADDR_W(28), .DATA_W(128), .IDX_W(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .mem_addr(ad0),
    .mem_wdata(wd0), .mem_rdata(q0), .mem_ready(rdy0), .busy(bz0)
`ifdef MEM_PROTOCOL_CHECK_EN
    , .proto_err(pe0)
`endif
  );

  line_mem_responder #(.ADDR_W(28), .DATA_W(128), .IDX_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .mem_addr(ad1),
    .mem_wdata(wd1), .mem_rdata(q1), .mem_ready(rdy1), .busy(bz1)
`ifdef MEM_PROTOCOL_CHECK_EN
    , .proto_err(pe1)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Raise a request just after an edge, wait for mem_ready, hold through the ready cycle,
  // then drop it after the next edge (the caller may immediately present another request).
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [27:0] addr, input logic [127:0] data,
                        output int lat, output logic [127:0] rdat, output int unsigned rcyc);
    int n;
    logic rdy;
    if (sel == 0) begin rd0 = rd; wr0 = wr; ad0 = addr; wd0 = data; end
    else          begin rd1 = rd; wr1 = wr; ad1 = addr; wd1 = data; end
    n = 0;
    lat = -1;
    rdat = '0;
    rcyc = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      rdy = (sel == 0) ? rdy0 : rdy1;
      if (rdy) begin
        lat  = n;
        rdat = (sel == 0) ? q0 : q1;
        rcyc = cyc;
        break;
      end
      if (n >= 300) begin
        check("ready_timeout", 128'(n), 128'(0));
        break;
      end
    end
    @(posedge clk); #1;
    check("busy_after_ready", (sel == 0) ? bz0 : bz1, 1'b0);
    if (sel == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
    else          begin rd1 = 1'b0; wr1 = 1'b0; end
  endtask

  localparam logic [127:0] LINE_DB = 128'h0123456789ABCDEF_00000000_DEADBEEF;
  localparam logic [127:0] LINE_A  = 128'hAAAA0000_11112222_33334444_5555AAAA;
  localparam logic [127:0] LINE_B  = 128'hBBBB0000_66667777_88889999_0000BBBB;
  localparam logic [127:0] LINE_C  = 128'hCCCCCCCC_CCCCCCCC_12345678_9ABCDEF0;
  localparam logic [127:0] LINE_D  = 128'hDDDD1111_DDDD2222_DDDD3333_DDDD4444;
  localparam logic [127:0] LINE_N  = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;

  logic [127:0] model [256];
  logic         written [256];

  initial begin
    int           lat;
    logic [127:0] rdat;
    int unsigned  rc1, rc2;
    logic [27:0]  waddr, raddr;
    logic [127:0] wdat;
    logic [7:0]   ridx;

    rst_n = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; ad0 = '0; wd0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; ad1 = '0; wd1 = '0;
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_ready", rdy0, 1'b0);
      check("idle_busy",  bz0,  1'b0);
      check("idle_rdata", q0,   '0);
    end
`ifdef MEM_PROTOCOL_CHECK_EN
    check("proto_err_clear", pe0, 1'b0);
`endif

    do_req(0, 1'b0, 1'b1, 28'h0000012, LINE_DB, lat, rdat, rc1);
    check("wr_latency", 128'(lat), 128'(4));
    do_req(0, 1'b1, 1'b0, 28'h0000012, '0, lat, rdat, rc1);
    check("rd_latency", 128'(lat), 128'(4));
    check("rd_deadbeef", rdat, LINE_DB);

    do_req(0, 1'b0, 1'b1, 28'h0000105, LINE_A, lat, rdat, rc1);
    do_req(0, 1'b0, 1'b1, 28'h0000005, LINE_B, lat, rdat, rc1);
    do_req(0, 1'b1, 1'b0, 28'h0000105, '0, lat, rdat, rc1);
    check("alias_rd", rdat, LINE_B);

    do_req(0, 1'b0, 1'b1, 28'h0000033, LINE_C, lat, rdat, rc1);
    do_req(0, 1'b1, 1'b0, 28'h0000033, '0, lat, rdat, rc2);
    check("b2b_spacing", 128'(rc2 - rc1), 128'(5));
    check("b2b_rd", rdat, LINE_C);

    // Both strobes high: write wins, read dropped, mem_rdata keeps the previous read line.
    do_req(0, 1'b1, 1'b1, 28'h0000040, LINE_D, lat, rdat, rc1);
    check("both_latency", 128'(lat), 128'(4));
    check("both_rdata_hold", rdat, LINE_C);
    do_req(0, 1'b1, 1'b0, 28'h0000040, '0, lat, rdat, rc1);
    check("both_write_won", rdat, LINE_D);
`ifdef MEM_PROTOCOL_CHECK_EN
    check("proto_err_set", pe0, 1'b1);
`endif

    // Reset in cycle 2 of a write: no ready, old line survives.
    wr0 = 1'b1; ad0 = 28'h0000012; wd0 = LINE_N;
    @(posedge clk); #1;
    check("mid_busy", bz0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; wr0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_busy",  bz0, 1'b0);
    check("rst_rdata", q0,  '0);
    for (int i = 0; i < 6; i++) begin
      check("rst_no_ready", rdy0, 1'b0);
      @(posedge clk); #1;
    end
    do_req(0, 1'b1, 1'b0, 28'h0000012, '0, lat, rdat, rc1);
    check("rst_old_line", rdat, LINE_DB);

    do_req(1, 1'b0, 1'b1, 28'h0000007, LINE_A, lat, rdat, rc1);
    check("l1_wr_latency", 128'(lat), 128'(1));
    do_req(1, 1'b1, 1'b0, 28'h0000007, '0, lat, rdat, rc1);
    check("l1_rd_latency", 128'(lat), 128'(1));
    check("l1_rd", rdat, LINE_A);
    model[8'h07] = LINE_A;
    written[8'h07] = 1'b1;

    for (int k = 0; k < 100; k++) begin
      waddr = 28'($urandom);
      wdat  = {$urandom, $urandom, $urandom, $urandom};
      do_req(1, 1'b0, 1'b1, waddr, wdat, lat, rdat, rc1);
      check("l1_rand_wr_lat", 128'(lat), 128'(1));
      model[waddr[7:0]]   = wdat;
      written[waddr[7:0]] = 1'b1;
      ridx = 8'($urandom_range(0, 255));
      if (!written[ridx]) ridx = waddr[7:0];
      raddr = {20'($urandom), ridx};
      do_req(1, 1'b1, 1'b0, raddr, '0, lat, rdat, rc1);
      check("l1_rand_rd_lat", 128'(lat), 128'(1));
      check("l1_rand_rd", rdat, model[ridx]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
